// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM style port bundle shared by the two masters and the SDRAM controller side.
// The master modport drives commands; the slave modport answers them.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 25
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [15:0]       writedata;
  logic [1:0]        byteenable;
  logic              waitrequest;
  logic [15:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-master SDRAM port arbiter: m0 has priority, m1 is protected by a starve counter,
// and an owner FIFO steers pipelined read data back to the master that issued the read.
module sdram_port_arbiter #(
  parameter int ADDR_W     = 25,
  parameter int MAX_PEND   = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  sdram_port_arbiter_if.slave  m0,
  sdram_port_arbiter_if.slave  m1,
  sdram_port_arbiter_if.master s
);

  localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state;
  logic [STV_W-1:0]  starve;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              fifo_owner [MAX_PEND];
  logic              rd_error;

  logic              req0, req1, arb_m1;
  logic              grant_valid, grant_m1, own0, own1;
  logic              g_read, g_write, read_blocked;
  logic [ADDR_W-1:0] g_address;
  logic              pop, fifo_ok, accept, push, head;

  // Read wins over write when a master asserts both.
  assign req0   = m0.read | m0.write;
  assign req1   = m1.read | m1.write;
  assign arb_m1 = req1 & (~req0 | (starve == STV_W'(STARVE_LIM)));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_m1    = 1'b0;
    unique case (state)
      OWN0:    grant_valid = 1'b1;
      OWN1: begin
        grant_valid = 1'b1;
        grant_m1    = 1'b1;
      end
      default: begin
        grant_valid = req0 | req1;
        grant_m1    = arb_m1;
      end
    endcase
  end

  assign own0      = grant_valid & ~grant_m1;
  assign own1      = grant_valid &  grant_m1;
  assign g_read    = grant_m1 ? m1.read : m0.read;
  assign g_write   = grant_m1 ? (m1.write & ~m1.read) : (m0.write & ~m0.read);
  assign g_address = grant_m1 ? m1.address : m0.address;

  // A pop in the same cycle frees the slot a full FIFO needs for the new read.
  assign pop          = s.readdatavalid & (count != '0);
  assign fifo_ok      = (count != CNT_W'(MAX_PEND)) | pop;
  assign read_blocked = g_read & ~fifo_ok;

  assign s.address    = g_address;
  assign s.writedata  = grant_m1 ? m1.writedata  : m0.writedata;
  assign s.byteenable = grant_m1 ? m1.byteenable : m0.byteenable;
  assign s.read       = ~reset & grant_valid & g_read & fifo_ok;
  assign s.write      = ~reset & grant_valid & g_write;

  assign accept = (s.read | s.write) & ~s.waitrequest;
  assign push   = s.read & ~s.waitrequest;
  assign head   = fifo_owner[rd_ptr];

  assign m0.waitrequest   = reset | (req0 & ~own0) | (own0 & read_blocked) | s.waitrequest;
  assign m1.waitrequest   = reset | (req1 & ~own1) | (own1 & read_blocked) | s.waitrequest;
  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;
  assign m0.readdatavalid = ~reset & pop & ~head;
  assign m1.readdatavalid = ~reset & pop &  head;

  // A command stalled by the controller locks the grant so s_* stays stable until accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      starve   <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      rd_error <= 1'b0;
    end else begin
      if ((s.read | s.write) & s.waitrequest)
        state <= grant_m1 ? OWN1 : OWN0;
      else
        state <= IDLE;

      if (~req1 | (accept & grant_m1))
        starve <= '0;
      else if (accept & ~grant_m1 & (starve != STV_W'(STARVE_LIM)))
        starve <= starve + STV_W'(1);

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);

      if (s.readdatavalid & (count == '0))
        rd_error <= 1'b1;
    end
  end

  // NOTE: owner storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clock) begin
    if (push) fifo_owner[wr_ptr] <= grant_m1;
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for the SDRAM port arbiter: ordering, starvation, FIFO full,
// stalled writes and reset with reads in flight, checked against hand-derived values.
module tb_sdram_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  sdram_port_arbiter_if #(.ADDR_W(25)) m0_if ();
  sdram_port_arbiter_if #(.ADDR_W(25)) m1_if ();
  sdram_port_arbiter_if #(.ADDR_W(25)) s_if ();

  sdram_port_arbiter #(
    .ADDR_W    (25),
    .MAX_PEND  (4),
    .STARVE_LIM(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .m0   (m0_if),
    .m1   (m1_if),
    .s    (s_if)
  );

  task automatic clear_inputs;
    m0_if.address = '0; m0_if.read = 1'b0; m0_if.write = 1'b0;
    m0_if.writedata = '0; m0_if.byteenable = '0;
    m1_if.address = '0; m1_if.read = 1'b0; m1_if.write = 1'b0;
    m1_if.writedata = '0; m1_if.byteenable = '0;
    s_if.waitrequest = 1'b0; s_if.readdata = '0; s_if.readdatavalid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clock);
    m0_if.read = 1'b1; m1_if.write = 1'b1; s_if.readdatavalid = 1'b1;
    #1;
    vectors++; if (s_if.read !== 1'b0) begin miscompares++; $display("FAIL rst_s_read got=%b exp=0", s_if.read); end
    vectors++; if (s_if.write !== 1'b0) begin miscompares++; $display("FAIL rst_s_write got=%b exp=0", s_if.write); end
    vectors++; if (m0_if.waitrequest !== 1'b1) begin miscompares++; $display("FAIL rst_m0_wait got=%b exp=1", m0_if.waitrequest); end
    vectors++; if (m1_if.waitrequest !== 1'b1) begin miscompares++; $display("FAIL rst_m1_wait got=%b exp=1", m1_if.waitrequest); end
    vectors++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== 2'b00) begin miscompares++; $display("FAIL rst_rdv got=%b exp=00", {m0_if.readdatavalid, m1_if.readdatavalid}); end
    @(negedge clock);
    clear_inputs();
    reset = 1'b0;
    #1;
    vectors++; if (dut.rd_error !== 1'b0) begin miscompares++; $display("FAIL rst_error got=%b exp=0", dut.rd_error); end
    vectors++; if (m0_if.waitrequest !== 1'b0) begin miscompares++; $display("FAIL rst_release_wait got=%b exp=0", m0_if.waitrequest); end
  endtask

  task automatic test_simultaneous_reads;
    @(negedge clock);
    m0_if.read = 1'b1; m0_if.address = 25'h100;
    m1_if.read = 1'b1; m1_if.address = 25'h200;
    #1;
    vectors++; if (s_if.read !== 1'b1 || s_if.address !== 25'h100) begin miscompares++; $display("FAIL sim_c0_addr got=%h/%b exp=100/1", s_if.address, s_if.read); end
    vectors++; if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b01) begin miscompares++; $display("FAIL sim_c0_wait got=%b exp=01", {m0_if.waitrequest, m1_if.waitrequest}); end
    @(negedge clock);
    m0_if.read = 1'b0;
    #1;
    vectors++; if (s_if.read !== 1'b1 || s_if.address !== 25'h200) begin miscompares++; $display("FAIL sim_c1_addr got=%h/%b exp=200/1", s_if.address, s_if.read); end
    vectors++; if (m1_if.waitrequest !== 1'b0) begin miscompares++; $display("FAIL sim_c1_wait got=%b exp=0", m1_if.waitrequest); end
    @(negedge clock);
    m1_if.read = 1'b0;
    s_if.readdatavalid = 1'b1; s_if.readdata = 16'hD000;
    #1;
    vectors++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== 2'b10 || m0_if.readdata !== 16'hD000) begin miscompares++; $display("FAIL sim_d0 got=%b/%h exp=10/d000", {m0_if.readdatavalid, m1_if.readdatavalid}, m0_if.readdata); end
    @(negedge clock);
    s_if.readdata = 16'hD111;
    #1;
    vectors++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== 2'b01 || m1_if.readdata !== 16'hD111) begin miscompares++; $display("FAIL sim_d1 got=%b/%h exp=01/d111", {m0_if.readdatavalid, m1_if.readdatavalid}, m1_if.readdata); end
    @(negedge clock);
    clear_inputs();
    #1;
    vectors++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== 2'b00) begin miscompares++; $display("FAIL sim_quiet got=%b exp=00", {m0_if.readdatavalid, m1_if.readdatavalid}); end
  endtask

  task automatic test_starvation;
    logic [24:0] exp_addr;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      m0_if.read = 1'b1; m0_if.address = 25'h10;
      m1_if.read = 1'b1; m1_if.address = 25'h20;
      s_if.readdatavalid = (i > 0); s_if.readdata = 16'(i);
      #1;
      exp_addr = (i < 8) ? 25'h10 : 25'h20;
      vectors++; if (s_if.read !== 1'b1 || s_if.address !== exp_addr) begin miscompares++; $display("FAIL starve_grant_%0d got=%h exp=%h", i, s_if.address, exp_addr); end
      if (i > 0) begin
        vectors++; if (m0_if.readdatavalid !== 1'b1) begin miscompares++; $display("FAIL starve_rdv_%0d got=%b exp=1", i, m0_if.readdatavalid); end
      end
    end
    vectors++; if (m0_if.waitrequest !== 1'b1) begin miscompares++; $display("FAIL starve_m0_held got=%b exp=1", m0_if.waitrequest); end
    @(negedge clock);
    m0_if.read = 1'b0; m1_if.read = 1'b0; s_if.readdatavalid = 1'b1;
    #1;
    vectors++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== 2'b01) begin miscompares++; $display("FAIL starve_drain got=%b exp=01", {m0_if.readdatavalid, m1_if.readdatavalid}); end
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic test_fifo_full;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      m1_if.read = 1'b1; m1_if.address = 25'h300 + 25'(i);
      #1;
      vectors++; if (s_if.read !== 1'b1 || m1_if.waitrequest !== 1'b0) begin miscompares++; $display("FAIL full_fill_%0d got=%b/%b exp=1/0", i, s_if.read, m1_if.waitrequest); end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      m1_if.address = 25'h304;
      #1;
      vectors++; if (s_if.read !== 1'b0 || m1_if.waitrequest !== 1'b1) begin miscompares++; $display("FAIL full_held_%0d got=%b/%b exp=0/1", i, s_if.read, m1_if.waitrequest); end
    end
    @(negedge clock);
    m0_if.write = 1'b1; m0_if.address = 25'h50; m0_if.writedata = 16'h1234; m0_if.byteenable = 2'b11;
    #1;
    vectors++; if (s_if.write !== 1'b1 || s_if.read !== 1'b0 || m0_if.waitrequest !== 1'b0) begin miscompares++; $display("FAIL full_write got=%b/%b/%b exp=1/0/0", s_if.write, s_if.read, m0_if.waitrequest); end
    @(negedge clock);
    m0_if.write = 1'b0;
    s_if.readdatavalid = 1'b1; s_if.readdata = 16'h0300;
    #1;
    vectors++; if (s_if.read !== 1'b1 || m1_if.waitrequest !== 1'b0 || s_if.address !== 25'h304) begin miscompares++; $display("FAIL full_popush got=%b/%b/%h exp=1/0/304", s_if.read, m1_if.waitrequest, s_if.address); end
    vectors++; if (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== 16'h0300) begin miscompares++; $display("FAIL full_pop_data got=%b/%h exp=1/0300", m1_if.readdatavalid, m1_if.readdata); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      m1_if.read = 1'b0;
      s_if.readdatavalid = 1'b1; s_if.readdata = 16'h0301 + 16'(i);
      #1;
      vectors++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== 2'b01) begin miscompares++; $display("FAIL full_drain_%0d got=%b exp=01", i, {m0_if.readdatavalid, m1_if.readdatavalid}); end
    end
    @(negedge clock);
    clear_inputs();
    #1;
    vectors++; if (dut.rd_error !== 1'b0) begin miscompares++; $display("FAIL full_no_error got=%b exp=0", dut.rd_error); end
  endtask

  task automatic test_write_hold;
    int writes = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      m0_if.write = 1'b1; m0_if.address = 25'h1234; m0_if.writedata = 16'hBEEF; m0_if.byteenable = 2'b10;
      m1_if.read = 1'b1; m1_if.address = 25'h777;
      s_if.waitrequest = (i < 3);
      #1;
      if (s_if.write && !s_if.waitrequest) writes++;
      vectors++; if (s_if.write !== 1'b1 || s_if.read !== 1'b0 || s_if.address !== 25'h1234 || s_if.writedata !== 16'hBEEF || s_if.byteenable !== 2'b10) begin
        miscompares++; $display("FAIL hold_bus_%0d got=%b%b/%h/%h/%b exp=10/1234/beef/10", i, s_if.write, s_if.read, s_if.address, s_if.writedata, s_if.byteenable);
      end
      vectors++; if (m1_if.waitrequest !== 1'b1) begin miscompares++; $display("FAIL hold_m1_wait_%0d got=%b exp=1", i, m1_if.waitrequest); end
      vectors++; if (m0_if.waitrequest !== (i < 3)) begin miscompares++; $display("FAIL hold_m0_wait_%0d got=%b exp=%b", i, m0_if.waitrequest, (i < 3)); end
    end
    @(negedge clock);
    clear_inputs();
    #1;
    vectors++; if (writes != 1) begin miscompares++; $display("FAIL hold_write_count got=%0d exp=1", writes); end
    vectors++; if (s_if.read !== 1'b0 || s_if.write !== 1'b0) begin miscompares++; $display("FAIL hold_idle got=%b%b exp=00", s_if.read, s_if.write); end
  endtask

  task automatic test_reset_midflight;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      m0_if.read = 1'b1; m0_if.address = 25'h40 + 25'(i);
      #1;
      vectors++; if (s_if.read !== 1'b1) begin miscompares++; $display("FAIL mid_issue_%0d got=%b exp=1", i, s_if.read); end
    end
    @(negedge clock);
    clear_inputs();
    reset = 1'b1;
    #1;
    vectors++; if (dut.count !== '0) begin miscompares++; $display("FAIL mid_fifo_empty got=%0d exp=0", dut.count); end
    vectors++; if (dut.state !== 2'd0) begin miscompares++; $display("FAIL mid_state_idle got=%0d exp=0", dut.state); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    s_if.readdatavalid = 1'b1; s_if.readdata = 16'hAAAA;
    #1;
    vectors++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== 2'b00) begin miscompares++; $display("FAIL mid_stray_rdv got=%b exp=00", {m0_if.readdatavalid, m1_if.readdatavalid}); end
    vectors++; if (dut.rd_error !== 1'b0) begin miscompares++; $display("FAIL mid_error_early got=%b exp=0", dut.rd_error); end
    @(negedge clock);
    s_if.readdatavalid = 1'b0;
    #1;
    vectors++; if (dut.rd_error !== 1'b1) begin miscompares++; $display("FAIL mid_error_set got=%b exp=1", dut.rd_error); end
    vectors++; if (dut.count !== '0) begin miscompares++; $display("FAIL mid_fifo_still_empty got=%0d exp=0", dut.count); end
    @(negedge clock);
    #1;
    vectors++; if (dut.rd_error !== 1'b1) begin miscompares++; $display("FAIL mid_error_sticky got=%b exp=1", dut.rd_error); end
  endtask

  initial begin
    clear_inputs();
    repeat (2) @(posedge clock);
    test_reset();
    test_simultaneous_reads();
    test_starvation();
    test_fifo_full();
    test_write_hold();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, SDRAM word-address width.
REQ-002 SHALL have parameter MAX_PEND, default 4, maximum outstanding reads; power of 2, 2..8.
REQ-003 SHALL have parameter STARVE_LIM, default 8, consecutive lost arbitrations before m1 is forced to win.
REQ-004 SHALL have port clock, in, 1: single clock for all logic.
REQ-005 SHALL have port reset, in, 1: asynchronous, active-high.
REQ-006 SHALL provide the following master ports for N=0 (A-bus bridge, priority) and N=1 (CPU) on every line from REQ-006 to REQ-009:
- mN_address, in, ADDR_W.
- mN_read, in, 1.
- mN_write, in, 1.
REQ-007 SHALL have ports mN_writedata, in, 16, and mN_byteenable, in, 2.
REQ-008 SHALL have port mN_waitrequest, out, 1: request not accepted this cycle.
REQ-009 SHALL have ports mN_readdata, out, 16, and mN_readdatavalid, out, 1.
REQ-010 SHALL provide the following slave-side ports toward the SDRAM controller:
- s_address, out, ADDR_W.
- s_read, out, 1.
- s_write, out, 1.
- s_writedata, out, 16.
- s_byteenable, out, 2.
REQ-011 SHALL have ports s_waitrequest, in, 1; s_readdata, in, 16; s_readdatavalid, in, 1.

Function
REQ-012 SHALL define a request from master N as mN_read OR mN_write; both asserted together is illegal and SHALL be treated as a read.
REQ-013 SHALL use FSM states IDLE, OWN0 and OWN1; state OWNn drives s_* from master n combinationally.
REQ-014 SHALL leave IDLE on the first request: m0 wins a tie unless the starve counter is at STARVE_LIM, in which case m1 wins; the grant takes effect the same cycle (zero added latency).
REQ-015 SHALL treat a transfer as accepted when s_read or s_write is high and s_waitrequest is low.
REQ-016 SHALL re-arbitrate per REQ-014 on acceptance; with no request pending, the FSM SHALL return to IDLE.
REQ-017 SHALL NOT change the grant while s_waitrequest is high, so the address, data and command stay stable.
REQ-018 SHALL hold mN_waitrequest high whenever master N is requesting and not granted, and SHALL otherwise pass s_waitrequest through.
REQ-019 SHALL increment the starve counter on each acceptance for m0 while m1 is requesting, saturating at STARVE_LIM; the counter SHALL clear on an acceptance for m1 or when m1 is idle.
REQ-020 SHALL push the owner ID of each accepted read into a MAX_PEND-deep FIFO with a wrapping pointer and a separate count.
REQ-021 SHALL, on s_readdatavalid, pop the FIFO head and route s_readdata to the owning mN_readdata and pulse that mN_readdatavalid for one cycle.
REQ-022 SHALL pulse the readdatavalid of the other master low and SHALL drive its readdata with s_readdata (harmless).
REQ-023 SHALL, when the FIFO is full, mask s_read low and hold the requester waiting; a same-cycle pop SHALL make space for a same-cycle push.
REQ-024 SHALL leave the FIFO unchanged on s_readdatavalid with an empty FIFO, and SHALL raise a sticky internal error flag readable in simulation.
REQ-025 SHALL not use the FIFO for writes; a write SHALL NOT wait for outstanding reads.
REQ-026 SHALL keep ownership of a held master: if master N drops its request while granted, the grant SHALL still hold until acceptance or until the next cycle without a request.

Reset
REQ-027 SHALL, while reset is high, put the FSM in IDLE, clear the starve counter, empty the FIFO, and clear the error flag.
REQ-028 SHALL, while reset is high, drive s_read, s_write, mN_readdatavalid low and mN_waitrequest high.
REQ-029 SHALL discard any reads that are in flight when reset is asserted mid-operation; any later readdatavalid SHALL be handled per REQ-024.

Verification
REQ-030 Bench SHALL show simultaneous reads, m0@0x100 and m1@0x200, s_waitrequest=0 -> m0 is accepted in cycle 0 and m1 in cycle 1; returned data D0 then D1 gives m0_readdatavalid first, then m1.
REQ-031 Bench SHALL show m0 requesting continuously with m1 requesting -> m1 is accepted no later than the 9th acceptance (STARVE_LIM=8).
REQ-032 Bench SHALL show 4 m1 reads accepted with no readdatavalid -> the 5th read is held, s_read=0 and m1_waitrequest=1; one readdatavalid -> the 5th read is accepted that cycle.
REQ-033 Bench SHALL show m0 write 0xBEEF, byteenable=2'b10, with s_waitrequest high for 3 cycles -> the s_* signals are stable for 4 cycles, m1 is never granted meanwhile, and one write is observed.
REQ-034 Bench SHALL show reset asserted with 2 reads pending, then released -> IDLE, FIFO empty; a stray readdatavalid sets the error flag and no mN_readdatavalid pulses.
